// File: rtl/uart_pkg.sv
// Shared types, parity constants and width helper for the UART transmitter.
// Parity generation is compiled in only when UART_TX_PARITY_EN is defined.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_state_t;

   localparam int PARITY_EVEN = 0;
   localparam int PARITY_ODD  = 1;

   // Width of a counter that must hold values 0..n-1, never narrower than 1 bit.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO holding queued transmit words; full and empty are registered
// from the next occupancy so they switch cleanly on the clock edge.
module uart_fifo import uart_pkg::*; #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = cnt_width(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count_next;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_comb begin
      count_next = count;
      if (do_push && !do_pop) begin
         count_next = count + CW'(1);
      end else if (do_pop && !do_push) begin
         count_next = count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count_next;
         full  <= (count_next == CW'(DEPTH));
         empty <= (count_next == '0);
      end
   end

   // Storage is not reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO: queued words go out back-to-back as
// start/data/[parity]/stop frames. Define UART_TX_PARITY_EN to add a parity bit.
module uart_tx_fifo import uart_pkg::*; #(
   parameter int BAUD_DIV   = 1250,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] data_in,
   input  logic                 tx_start,
   output logic                 full,
   output logic                 tx_busy,
   output logic                 tx_done,
   output logic                 overflow,
   output logic                 tx_pin
);

   localparam int CNT_W = cnt_width(BAUD_DIV);
   localparam int IDX_W = cnt_width(DATA_BITS + 1);
   localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

   if (BAUD_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
       (STOP_BITS != 1 && STOP_BITS != 2) ||
       (PARITY_ODD != PARITY_EVEN && PARITY_ODD != uart_pkg::PARITY_ODD) ||
       FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
      $error("uart_tx_fifo: unsupported parameter set");
   end

   uart_state_t          state;
   logic [CNT_W-1:0]     baud_cnt;
   logic [IDX_W-1:0]     bit_idx;
   logic                 stop_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic [DATA_BITS-1:0] fifo_dout;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [OCC_W-1:0]     fifo_count;
   logic                 push;
   logic                 pop;
   logic                 bit_end;
   logic                 frame_end;
   logic                 line_bit;
`ifdef UART_TX_PARITY_EN
   logic                 par_bit;
`endif

   uart_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   (data_in),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign full      = fifo_full;
   assign push      = tx_start && !fifo_full;
   assign bit_end   = (baud_cnt == '0);
   assign frame_end = (state == ST_STOP) && bit_end && (stop_cnt == STOP_LAST);
   // A word is taken either from idle or straight out of the last stop bit.
   assign pop       = !fifo_empty && ((state == ST_IDLE) || frame_end);

   always_comb begin
      line_bit = 1'b1;
      case (state)
         ST_START:  line_bit = 1'b0;
         ST_DATA:   line_bit = shreg[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: line_bit = par_bit;
`endif
         default:   line_bit = 1'b1;
      endcase
   end

   // The pad copies the state's bit one cycle later, so every output is a flop.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         stop_cnt <= 1'b0;
         shreg    <= '0;
         tx_pin   <= 1'b1;
         tx_busy  <= 1'b0;
         tx_done  <= 1'b0;
         overflow <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_bit  <= 1'b0;
`endif
      end else begin
         tx_pin   <= line_bit;
         tx_busy  <= (state != ST_IDLE);
         tx_done  <= frame_end;
         overflow <= tx_start && (fifo_count == OCC_W'(FIFO_DEPTH));
         if (!bit_end) baud_cnt <= baud_cnt - CNT_W'(1);

         if (pop) begin
            shreg    <= fifo_dout;
            baud_cnt <= BIT_LAST;
            state    <= ST_START;
`ifdef UART_TX_PARITY_EN
            par_bit  <= (^fifo_dout) ^ (PARITY_ODD == uart_pkg::PARITY_ODD);
`endif
         end else begin
            case (state)
               ST_IDLE: ;
               ST_START: begin
                  if (bit_end) begin
                     baud_cnt <= BIT_LAST;
                     bit_idx  <= '0;
                     state    <= ST_DATA;
                  end
               end
               ST_DATA: begin
                  if (bit_end) begin
                     baud_cnt <= BIT_LAST;
                     shreg    <= shreg >> 1;
                     if (bit_idx == DATA_LAST) begin
                        stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        state    <= ST_PARITY;
`else
                        state    <= ST_STOP;
`endif
                     end else begin
                        bit_idx <= bit_idx + IDX_W'(1);
                     end
                  end
               end
`ifdef UART_TX_PARITY_EN
               ST_PARITY: begin
                  if (bit_end) begin
                     baud_cnt <= BIT_LAST;
                     stop_cnt <= 1'b0;
                     state    <= ST_STOP;
                  end
               end
`endif
               ST_STOP: begin
                  if (bit_end) begin
                     if (stop_cnt == STOP_LAST) begin
                        state <= ST_IDLE;
                     end else begin
                        stop_cnt <= 1'b1;
                        baud_cnt <= BIT_LAST;
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a frame-schedule reference model predicts every output
// each cycle; a second instance covers the 5-data-bit, 2-stop-bit format.
module tb_uart_tx_fifo;

   localparam int B     = 4;
   localparam int D     = 8;
   localparam int S     = 1;
   localparam int DEPTH = 4;
   localparam int B5    = 3;
   localparam int D5    = 5;
   localparam int S5    = 2;
`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int F  = (1 + D + P + S) * B;
   localparam int F5 = (1 + D5 + P + S5) * B5;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tx_start;
   logic [7:0] data_in;
   logic       full, tx_busy, tx_done, overflow, tx_pin;
   logic       start5;
   logic [4:0] data5;
   logic       full5, busy5, done5, ovf5, pin5;

   always #5 clk = ~clk;

   uart_tx_fifo #(
      .BAUD_DIV (B), .DATA_BITS (D), .STOP_BITS (S), .PARITY_ODD (0), .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk (clk), .rst_n (rst_n), .data_in (data_in), .tx_start (tx_start),
      .full (full), .tx_busy (tx_busy), .tx_done (tx_done), .overflow (overflow), .tx_pin (tx_pin)
   );

   uart_tx_fifo #(
      .BAUD_DIV (B5), .DATA_BITS (D5), .STOP_BITS (S5), .PARITY_ODD (1), .FIFO_DEPTH (2)
   ) dut5 (
      .clk (clk), .rst_n (rst_n), .data_in (data5), .tx_start (start5),
      .full (full5), .tx_busy (busy5), .tx_done (done5), .overflow (ovf5), .tx_pin (pin5)
   );

   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         done_cnt = 0;
   int         done5_cnt = 0;
   int         fr_start[$];
   logic [7:0] fr_word[$];
   logic       exp_ovf = 1'b0;
   int         e0, lo, dn, busy_cyc, ovf_cnt, n0, s0, low_cnt, e5, k;
   logic       full_seen;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   // Line level for bit slot k of a frame: start, nd data bits LSB first, [parity], stop.
   function automatic logic frame_bit(input logic [8:0] w, input int k, input int nd, input bit odd);
      logic [8:0] m;
      m = w & ((9'd1 << nd) - 9'd1);
      if (k == 0) return 1'b0;
      if (k <= nd) return w[k-1];
      if (P == 1 && k == nd + 1) return (^m) ^ odd;
      return 1'b1;
   endfunction

   // Each accepted word gets a line start: two cycles after its push when the
   // line is free, otherwise right after the previous frame.
   task automatic model_edge(input logic r, input logic s, input logic [7:0] d);
      int occ, pop_at;
      exp_ovf = 1'b0;
      if (!r) begin
         fr_start.delete();
         fr_word.delete();
         return;
      end
      occ = 0;
      foreach (fr_start[i]) if (fr_start[i] - 1 >= cyc) occ++;
      if (s && occ == DEPTH) begin
         exp_ovf = 1'b1;
      end else if (s) begin
         pop_at = cyc + 1;
         if (fr_start.size() > 0 && fr_start[fr_start.size()-1] + F - 1 > pop_at)
            pop_at = fr_start[fr_start.size()-1] + F - 1;
         fr_start.push_back(pop_at + 1);
         fr_word.push_back(d);
      end
   endtask

   task automatic check_main();
      logic ep, eb, ed;
      int   occ_after;
      ep = 1'b1; eb = 1'b0; ed = 1'b0; occ_after = 0;
      foreach (fr_start[i]) begin
         if (cyc >= fr_start[i] && cyc < fr_start[i] + F) begin
            ep = frame_bit({1'b0, fr_word[i]}, (cyc - fr_start[i]) / B, D, 1'b0);
            eb = 1'b1;
         end
         if (cyc == fr_start[i] + F - 1) ed = 1'b1;
         if (fr_start[i] - 1 > cyc) occ_after++;
      end
      chk("tx_pin", tx_pin, ep);
      chk("tx_busy", tx_busy, eb);
      chk("tx_done", tx_done, ed);
      chk("full", full, occ_after == DEPTH);
      chk("overflow", overflow, exp_ovf);
   endtask

   task automatic step(input logic r, input logic s, input logic [7:0] d,
                       input logic s5, input logic [4:0] d5);
      @(negedge clk);
      rst_n = r; tx_start = s; data_in = d; start5 = s5; data5 = d5;
      @(posedge clk);
      cyc++;
      model_edge(r, s, d);
      #1;
      if (tx_done) done_cnt++;
      if (done5) done5_cnt++;
      check_main();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 5'd0);
   endtask

   initial begin
      rst_n = 1'b0; tx_start = 1'b0; data_in = 8'h00; start5 = 1'b0; data5 = 5'd0;

      // reset
      repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0, 5'd0);
      chk("rst_pin5", pin5, 1'b1);
      chk("rst_busy5", busy5, 1'b0);
      chk("rst_full5", full5, 1'b0);
      chk("rst_done5", done5, 1'b0);
      chk("rst_ovf5", ovf5, 1'b0);
      idle(2);

      // basic frame
      done_cnt = 0; lo = -1; dn = -1;
      step(1'b1, 1'b1, 8'b10011010, 1'b0, 5'd0);
      e0 = cyc;
      for (int i = 0; i < F + 10; i++) begin
         step(1'b1, 1'b0, 8'h00, 1'b0, 5'd0);
         if (lo < 0 && tx_pin == 1'b0) lo = cyc;
         if (dn < 0 && tx_done) dn = cyc;
      end
      chk("basic_first_low", lo, e0 + 2);
      chk("basic_done_at", dn, e0 + 2 + F - 1);
      chk("basic_done_count", done_cnt, 1);

      // back-to-back
      done_cnt = 0; busy_cyc = 0;
      step(1'b1, 1'b1, 8'h55, 1'b0, 5'd0);
      step(1'b1, 1'b1, 8'hA3, 1'b0, 5'd0);
      step(1'b1, 1'b1, 8'h0F, 1'b0, 5'd0);
      for (int i = 0; i < 3 * F + 10; i++) begin
         step(1'b1, 1'b0, 8'h00, 1'b0, 5'd0);
         if (tx_busy) busy_cyc++;
      end
      chk("b2b_busy_cycles", busy_cyc, 3 * F - 1);
      chk("b2b_done_count", done_cnt, 3);

      // overflow
      done_cnt = 0; ovf_cnt = 0; full_seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b1, 8'(8'h10 + i), 1'b0, 5'd0);
         if (overflow) ovf_cnt++;
         if (full) full_seen = 1'b1;
      end
      idle(5 * F + 10);
      chk("ovf_pulses", ovf_cnt, 1);
      chk("ovf_full_seen", full_seen, 1'b1);
      chk("ovf_frames_sent", done_cnt, 5);

      // random traffic
      for (int i = 0; i < 600; i++)
         step(1'b1, $urandom_range(0, 3) == 0, 8'($urandom_range(0, 255)), 1'b0, 5'd0);
      idle((DEPTH + 2) * F);
      chk("rand_drained", tx_busy, 1'b0);

      // reset in the middle of data bit 3 with two words queued
      n0 = fr_start.size();
      step(1'b1, 1'b1, 8'h3C, 1'b0, 5'd0);
      step(1'b1, 1'b1, 8'hC5, 1'b0, 5'd0);
      step(1'b1, 1'b1, 8'h7E, 1'b0, 5'd0);
      s0 = fr_start[n0];
      for (int i = 0; i < 8 * B && cyc < s0 + 4 * B + 1; i++) idle(1);
      step(1'b0, 1'b0, 8'h00, 1'b0, 5'd0);
      chk("rstmid_pin", tx_pin, 1'b1);
      chk("rstmid_busy", tx_busy, 1'b0);
      chk("rstmid_full", full, 1'b0);
      done_cnt = 0; low_cnt = 0;
      for (int i = 0; i < 3 * F; i++) begin
         idle(1);
         if (tx_pin == 1'b0) low_cnt++;
      end
      chk("rstmid_no_frames", done_cnt, 0);
      chk("rstmid_line_idle", low_cnt, 0);

      // 5 data bits, 2 stop bits
      done5_cnt = 0;
      step(1'b1, 1'b0, 8'h00, 1'b1, 5'b10110);
      e5 = cyc;
      for (int i = 0; i < F5 + 6; i++) begin
         idle(1);
         k = cyc - (e5 + 2);
         chk("fmt_pin", pin5, (k >= 0 && k < F5) ? frame_bit({4'b0000, 5'b10110}, k / B5, D5, 1'b1) : 1'b1);
         chk("fmt_done", done5, k == F5 - 1);
      end
      chk("fmt_done_count", done5_cnt, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
